// File: rtl/lsu_bus_ctrl_pkg.sv
// rtl/lsu_bus_ctrl_pkg.sv - shared LSU types and byte-enable constants (LSU_MISALIGN_SPLIT_EN adds split states)
package lsu_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } memaccess_t;

  typedef enum logic [2:0] {
    MASK_BYTE   = 3'd0,
    MASK_BYTE_U = 3'd1,
    MASK_HALF   = 3'd2,
    MASK_HALF_U = 3'd3,
    MASK_WORD   = 3'd4
  } mask_mode_t;

  // Split states only exist when misaligned accesses are broken into two words.
  typedef enum logic [2:0] {
    LSU_IDLE       = 3'd0,
    LSU_REQ        = 3'd1,
    LSU_WAIT_R     = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    LSU_SPLIT_REQ  = 3'd4,
    LSU_SPLIT_WAIT = 3'd5,
`endif
    LSU_DONE       = 3'd3
  } lsu_state_t;

  localparam logic [3:0] BUS_BE_WORD = 4'b1111;
  localparam logic [3:0] BUS_BE_HALF = 4'b0011;
  localparam logic [3:0] BUS_BE_BYTE = 4'b0001;

endpackage

// File: rtl/lsu_bus_ctrl_be_gen.sv
// rtl/lsu_bus_ctrl_be_gen.sv - lsu_be_gen: lane alignment of byte enables/store data and misalign detect
module lsu_be_gen
  import lsu_bus_ctrl_pkg::*;
(
  input  mask_mode_t  mask_mode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic        misalign_o
);

  logic [3:0] be_base;

  // Enables and data are produced over two words so a split access can take
  // the upper half directly; an in-word access only ever lights the low half.
  always_comb begin
    be_base    = BUS_BE_WORD;
    misalign_o = 1'b0;
    case (mask_mode_i)
      MASK_BYTE, MASK_BYTE_U: be_base = BUS_BE_BYTE;
      MASK_HALF, MASK_HALF_U: begin
        be_base    = BUS_BE_HALF;
        misalign_o = (off_i == 2'd3);
      end
      default: begin
        be_base    = BUS_BE_WORD;
        misalign_o = (off_i != 2'd0);
      end
    endcase
    be_o    = {4'b0000, be_base} << off_i;
    wdata_o = {32'd0, wdata_i} << {off_i, 3'b000};
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - MEM-stage data bus controller; LSU_MISALIGN_SPLIT_EN splits misaligned accesses
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  memaccess_t        req_memaccess,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  mask_mode_t        req_mask_mode,
  output logic              lsu_stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_byte_offset,
  output logic              lsu_fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic              split_q, split_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [7:0]        gen_be;
  logic [63:0]       gen_wdata;
  logic              gen_misalign;
  logic              req_valid;
  logic              timeout_hit;
  logic              hi_sel;

  lsu_be_gen u_be_gen (
    .mask_mode_i (req_mask_mode),
    .off_i       (req_addr[1:0]),
    .wdata_i     (req_wdata),
    .be_o        (gen_be),
    .wdata_o     (gen_wdata),
    .misalign_o  (gen_misalign)
  );

  assign req_valid   = (req_memaccess != MEM_NONE);
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [63:0] merged;
  assign merged = {bus_rdata, lo_q} >> {off_q, 3'b000};
  assign hi_sel = (state_q == LSU_SPLIT_REQ);
`else
  assign hi_sel = 1'b0;
`endif

  // Bus side is quiet outside request phases; the upper word is used only for a split second half.
  assign bus_we           = bus_req & we_q;
  assign bus_addr         = !bus_req ? '0 : (hi_sel ? addr_q + ADDR_W'(4) : addr_q);
  assign bus_be           = !bus_req ? 4'd0 : (hi_sel ? be_q[7:4] : be_q[3:0]);
  assign bus_wdata        = !bus_req ? 32'd0 : (hi_sel ? wdata_q[63:32] : wdata_q[31:0]);
  assign resp_rdata       = rdata_q;
  assign resp_byte_offset = split_q ? 2'd0 : off_q;

  // Next-state, request latching and handshake outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    split_d    = split_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q + 16'd1;
    lsu_stall  = rst_n;
    resp_valid = 1'b0;
    lsu_fault  = 1'b0;
    bus_req    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        lsu_stall = rst_n & req_valid;
        cnt_d     = '0;
        if (req_valid) begin
          we_d    = (req_memaccess == MEM_WRITE);
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          be_d    = gen_be;
          wdata_d = gen_wdata;
          off_d   = req_addr[1:0];
          lo_d    = '0;
          rdata_d = '0;
          fault_d = 1'b0;
          split_d = gen_misalign & SPLIT_EN;
          if (gen_misalign && !SPLIT_EN) begin
            // Unsupported alignment never reaches the bus: fault now, complete next cycle.
            lsu_fault = rst_n;
            state_d   = LSU_DONE;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = LSU_WAIT_R;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_WAIT_R: begin
        if (bus_rvalid) begin
          cnt_d   = '0;
          fault_d = fault_q | bus_err;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            lo_d    = bus_rdata;
            state_d = LSU_SPLIT_REQ;
          end else
`endif
          begin
            rdata_d = (we_q || bus_err) ? 32'd0 : bus_rdata;
            state_d = LSU_DONE;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = LSU_DONE;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      LSU_SPLIT_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = LSU_SPLIT_WAIT;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_SPLIT_WAIT: begin
        if (bus_rvalid) begin
          cnt_d   = '0;
          rdata_d = (we_q || fault_q || bus_err) ? 32'd0 : merged[31:0];
          fault_d = fault_q | bus_err;
          state_d = LSU_DONE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = LSU_DONE;
        end
      end
`endif
      LSU_DONE: begin
        lsu_stall  = 1'b0;
        resp_valid = 1'b1;
        lsu_fault  = fault_q;
        cnt_d      = '0;
        state_d    = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and latched request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      split_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
